record_core: RTL and testbench
==============================

Name: record_core

Overview:
- Capture engine writing one audio clip into SDRAM in the layout the mixer/player consumes.
- Clip layout: header word at base address holds sample count N in bits [22:0], upper bits zero. Samples occupy base+1 .. base+N.
- Sits between the audio-in valid/ready stream and the shared SDRAM write port. A small FIFO absorbs SDRAM latency.
- The header is written last, once N is known.

Parameters:
- ADDR_W, 23, SDRAM word address width
- DATA_W, 32, sample/word width (stereo 2x16)
- FIFO_DEPTH, 8, sample FIFO entries, power of 2, >=2

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- rec_start  in  1  one-cycle pulse; begin a clip (ignored unless IDLE)
- rec_base  in  ADDR_W  clip base address, sampled on rec_start
- rec_max_len  in  ADDR_W  max samples, sampled on rec_start; 0 means no samples
- rec_stop  in  1  finalize the clip early (not an abort)
- rec_busy  out  1  high from the cycle after accepted rec_start until rec_done
- rec_done  out  1  one-cycle pulse after the header write completes
- rec_length  out  ADDR_W  N of the last finished clip, held until the next start
- rec_audio_valid  in  1  input sample valid
- rec_audio_data  in  DATA_W  input sample
- rec_audio_ready  out  1  sample accepted when valid&&ready on a clock edge
- rec_write  out  1  SDRAM write request
- rec_addr  out  ADDR_W  SDRAM word address
- rec_writedata  out  DATA_W  SDRAM write data
- rec_sdram_finished  in  1  write completed this cycle (meaningful only while rec_write=1)

Behaviour:
- Reset: state IDLE, all counters/FIFO cleared. All outputs are 0: rec_busy, rec_done, rec_length, rec_audio_ready, rec_write, rec_addr, rec_writedata.
- States: IDLE, CAPTURE, DRAIN, HEADER, DONE.
- IDLE -> CAPTURE on rec_start. Latch base and max. Clear acc_cnt, wr_cnt and FIFO.
- CAPTURE:
  - rec_audio_ready = !fifo_full && acc_cnt < max && !rec_stop.
  - Each accepted sample is pushed (subject to the optional feature) and increments acc_cnt.
  - Move to DRAIN when acc_cnt reaches max, or on rec_stop. rec_stop wins over a same-cycle sample: that sample is not accepted.
- Write port (CAPTURE and DRAIN):
  - rec_write = !fifo_empty.
  - rec_addr = base+1+wr_cnt; rec_writedata = FIFO head (first-word-fall-through).
  - Address and data stay stable while rec_write=1 and finished=0.
  - On finished: pop the FIFO and increment wr_cnt. The next request may assert the following cycle.
- Latency: a sample accepted at edge t is visible on rec_write/rec_writedata at t+1.
- DRAIN -> HEADER when the FIFO is empty and no write is pending.
- HEADER: rec_write=1, rec_addr=base, rec_writedata={zeros, wr_cnt}. On finished: go to DONE and load rec_length=wr_cnt.
- DONE: rec_done=1 for one cycle, then IDLE; rec_busy drops with it.
- Arithmetic: base+1+wr_cnt wraps modulo 2^ADDR_W with no error flag. N <= 2^ADDR_W-1.
- Boundary cases:
  - max=0: no samples accepted. HEADER writes 0; the resulting clip has length 0.
  - FIFO full: ready=0; the source must hold valid/data.
  - Simultaneous push and pop on a full/empty FIFO are both legal.
  - rec_stop in DRAIN or HEADER has no effect. rec_stop in IDLE is ignored.
  - rec_start while busy is ignored.
  - i_rst mid-clip abandons the clip; the header is not written.

Optional Feature:
- Macro: RECORD_CORE_DECIMATE_EN.
- Enabled: a 1-bit phase toggles on every accepted sample. Only phase-0 samples are pushed and counted in wr_cnt; phase-1 samples are still handshaked. Phase resets on start. This matches the player's 2x zero-order hold.
  - acc_cnt counts pushed samples, so max limits stored samples.
  - A stop after an odd number of accepts stores ceil(accepts/2) samples.
- Disabled: every accepted sample is stored.

Decomposition:
- Package rec_pkg:
  - state enum rec_state_t.
  - ADDR_W/DATA_W defaults.
  - Header-word packing function hdr_word(len) = {zeros, len[22:0]}.
- One sub-module rec_fifo: synchronous first-word-fall-through FIFO with DEPTH parameter and full/empty/push/pop ports, async reset.

Test Plan:
- Basic clip: base=0x100, max=3, samples 0xA,0xB,0xC, finished=1 immediately. Writes [0x101]=A, [0x102]=B, [0x103]=C, then [0x100]=3. rec_done pulses once; rec_length=3.
- SDRAM stalls: finished delayed 5 cycles per write, source streams 12 samples with max=12. ready drops when 8 are queued. Address and data stay stable during each stall. All 12 samples are stored in order; header = 12.
- Early stop: max=100, stop after 4 accepted, with valid high in the stop cycle. That sample is not accepted; header = 4; no writes beyond base+4.
- max=0: start then run. Single write [base]=0, rec_done pulses, ready never high.
- Reset mid-DRAIN: assert i_rst with 2 queued. All outputs go to 0 next edge and no header write occurs. A new start then records correctly.
- Decimation (macro on): 6 accepts D0..D5, max=10, then stop. Stores D0,D2,D4; header = 3. With the macro off, the same stimulus gives header = 6.

Source files
------------

// File: rtl/rec_pkg.sv
// Shared types and constants for the clip recorder: FSM state encoding and header packing.
package rec_pkg;

   localparam int ADDR_W_DEF = 23;
   localparam int DATA_W_DEF = 32;
   localparam int HDR_LEN_W  = 23;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_DRAIN,
      ST_HEADER,
      ST_DONE
   } rec_state_t;

   // Header word as the mixer/player reads it: length in the low bits, upper bits zero.
   function automatic logic [DATA_W_DEF-1:0] hdr_word(input logic [HDR_LEN_W-1:0] len);
      hdr_word = {{(DATA_W_DEF-HDR_LEN_W){1'b0}}, len};
   endfunction

endpackage

// File: rtl/rec_fifo.sv
// First-word-fall-through sample FIFO; dout shows the head whenever empty is low.
// clr empties the FIFO synchronously at the start of a new clip.
module rec_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_pop;
   logic             do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push on a full FIFO is still legal.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/record_core.sv
// Records one audio clip into SDRAM: samples at base+1.., header (length) at base, written last.
// Build option: define RECORD_CORE_DECIMATE_EN to store only every other accepted sample.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for rec_start
// ST_CAPTURE | accepting samples into the FIFO and writing them out
// ST_DRAIN   | no more input; flushing queued samples to SDRAM
// ST_HEADER  | writing the length word at base
// ST_DONE    | one-cycle rec_done pulse, then back to idle
module record_core
   import rec_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              rec_start,
   input  logic [ADDR_W-1:0] rec_base,
   input  logic [ADDR_W-1:0] rec_max_len,
   input  logic              rec_stop,
   output logic              rec_busy,
   output logic              rec_done,
   output logic [ADDR_W-1:0] rec_length,
   input  logic              rec_audio_valid,
   input  logic [DATA_W-1:0] rec_audio_data,
   output logic              rec_audio_ready,
   output logic              rec_write,
   output logic [ADDR_W-1:0] rec_addr,
   output logic [DATA_W-1:0] rec_writedata,
   input  logic              rec_sdram_finished
);

   rec_state_t        state;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] max_len;
   logic [ADDR_W-1:0] acc_cnt;
   logic [ADDR_W-1:0] acc_next;
   logic [ADDR_W-1:0] wr_cnt;

   logic              capturing;
   logic              streaming;
   logic              accept;
   logic              push;
   logic              pop;
   logic              fifo_clr;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_dout;

   assign capturing = (state == ST_CAPTURE);
   assign streaming = capturing || (state == ST_DRAIN);

   // A same-cycle stop blocks the sample, so the clip ends on exactly the samples seen before it.
   assign rec_audio_ready = capturing && !fifo_full && (acc_cnt < max_len) && !rec_stop;
   assign accept          = rec_audio_valid && rec_audio_ready;

`ifdef RECORD_CORE_DECIMATE_EN
   logic phase;
   assign push = accept && !phase;
`else
   assign push = accept;
`endif

   assign pop      = streaming && !fifo_empty && rec_sdram_finished;
   assign acc_next = acc_cnt + ADDR_W'(push);
   assign fifo_clr = (state == ST_IDLE) && rec_start;

   rec_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .clr   (fifo_clr),
      .push  (push),
      .pop   (pop),
      .din   (rec_audio_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      rec_write     = 1'b0;
      rec_addr      = '0;
      rec_writedata = '0;
      if (streaming && !fifo_empty) begin
         rec_write     = 1'b1;
         rec_addr      = base + ADDR_W'(1) + wr_cnt;
         rec_writedata = fifo_dout;
      end else if (state == ST_HEADER) begin
         rec_write     = 1'b1;
         rec_addr      = base;
         rec_writedata = DATA_W'(hdr_word(HDR_LEN_W'(wr_cnt)));
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         base       <= '0;
         max_len    <= '0;
         acc_cnt    <= '0;
         wr_cnt     <= '0;
         rec_busy   <= 1'b0;
         rec_done   <= 1'b0;
         rec_length <= '0;
`ifdef RECORD_CORE_DECIMATE_EN
         phase      <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               rec_done <= 1'b0;
               if (rec_start) begin
                  base     <= rec_base;
                  max_len  <= rec_max_len;
                  acc_cnt  <= '0;
                  wr_cnt   <= '0;
                  rec_busy <= 1'b1;
                  state    <= ST_CAPTURE;
`ifdef RECORD_CORE_DECIMATE_EN
                  phase    <= 1'b0;
`endif
               end
            end
            ST_CAPTURE: begin
               acc_cnt <= acc_next;
               if (pop) wr_cnt <= wr_cnt + ADDR_W'(1);
`ifdef RECORD_CORE_DECIMATE_EN
               if (accept) phase <= ~phase;
`endif
               if (rec_stop || (acc_next == max_len)) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (pop) wr_cnt <= wr_cnt + ADDR_W'(1);
               if (fifo_empty) state <= ST_HEADER;
            end
            ST_HEADER: begin
               if (rec_sdram_finished) begin
                  rec_length <= wr_cnt;
                  rec_done   <= 1'b1;
                  state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               rec_done <= 1'b0;
               rec_busy <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_record_core.sv
// Self-checking bench for record_core: randomized clips against a list-level model of the stored clip.
module tb_record_core;

   localparam int AW = 23;
   localparam int DW = 32;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          rec_start = 1'b0;
   logic [AW-1:0] rec_base = '0;
   logic [AW-1:0] rec_max_len = '0;
   logic          rec_stop = 1'b0;
   logic          rec_busy;
   logic          rec_done;
   logic [AW-1:0] rec_length;
   logic          rec_audio_valid = 1'b0;
   logic [DW-1:0] rec_audio_data = '0;
   logic          rec_audio_ready;
   logic          rec_write;
   logic [AW-1:0] rec_addr;
   logic [DW-1:0] rec_writedata;
   logic          rec_sdram_finished = 1'b0;

   record_core #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(8)) dut (
      .i_clk              (i_clk),
      .i_rst              (i_rst),
      .rec_start          (rec_start),
      .rec_base           (rec_base),
      .rec_max_len        (rec_max_len),
      .rec_stop           (rec_stop),
      .rec_busy           (rec_busy),
      .rec_done           (rec_done),
      .rec_length         (rec_length),
      .rec_audio_valid    (rec_audio_valid),
      .rec_audio_data     (rec_audio_data),
      .rec_audio_ready    (rec_audio_ready),
      .rec_write          (rec_write),
      .rec_addr           (rec_addr),
      .rec_writedata      (rec_writedata),
      .rec_sdram_finished (rec_sdram_finished)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad = 0;

   int            lat = 0;
   int            wait_cnt = 0;
   bit            pend = 0;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] p_data;
   logic [AW-1:0] wq_addr[$];
   logic [DW-1:0] wq_data[$];
   logic [DW-1:0] samp[$];
   int            n_acc = 0;
   int            stab_bad = 0;
   int            done_cnt = 0;
   int            ready_hi = 0;
   int            full_seen = 0;
   int            full_viol = 0;

   // SDRAM responder and bus monitor; a write decided here completes on the next rising edge.
   always @(negedge i_clk) begin
      if (i_rst) begin
         rec_sdram_finished = 1'b0;
         wait_cnt = 0;
         pend = 0;
      end else begin
         if (rec_done) done_cnt++;
         if (rec_audio_ready) ready_hi++;
`ifndef RECORD_CORE_DECIMATE_EN
         if (n_acc - wq_addr.size() == 8) begin
            full_seen++;
            if (rec_audio_ready) full_viol++;
         end
`endif
         if (rec_write) begin
            if (pend && (rec_addr !== p_addr || rec_writedata !== p_data)) stab_bad++;
            if (wait_cnt >= lat) begin
               rec_sdram_finished = 1'b1;
               wq_addr.push_back(rec_addr);
               wq_data.push_back(rec_writedata);
               wait_cnt = 0;
               pend = 0;
            end else begin
               rec_sdram_finished = 1'b0;
               wait_cnt++;
               pend = 1;
               p_addr = rec_addr;
               p_data = rec_writedata;
            end
         end else begin
            rec_sdram_finished = 1'b0;
            if (pend) stab_bad++;
            pend = 0;
            wait_cnt = 0;
         end
      end
   end

   // Number of samples the source gets to hand over before the clip closes.
   function automatic int exp_accepts(input int n, input int stop_at, input int mx);
      int k;
      int lim;
      k = n;
      if (stop_at >= 0 && stop_at < k) k = stop_at;
`ifdef RECORD_CORE_DECIMATE_EN
      lim = (mx == 0) ? 0 : 2 * mx - 1;
`else
      lim = mx;
`endif
      if (lim < k) k = lim;
      return k;
   endfunction

   task automatic prep_clip(input int l);
      wq_addr.delete();
      wq_data.delete();
      n_acc = 0;
      done_cnt = 0;
      ready_hi = 0;
      stab_bad = 0;
      full_seen = 0;
      full_viol = 0;
      lat = l;
   endtask

   task automatic start_clip(input logic [AW-1:0] base, input logic [AW-1:0] mx);
      rec_base = base;
      rec_max_len = mx;
      rec_start = 1'b1;
      @(posedge i_clk); #1;
      rec_start = 1'b0;
   endtask

   task automatic run_clip(input logic [AW-1:0] base, input logic [AW-1:0] mx,
                           input int stop_at, input int l);
      int  n;
      int  cyc;
      bit  stopped;
      bit  stop_now;
      bit  hs;
      n = samp.size();
      prep_clip(l);
      start_clip(base, mx);
      // a second start while busy must not retarget the clip
      rec_base = ~base;
      rec_max_len = mx + 5;
      rec_start = 1'b1;
      @(posedge i_clk); #1;
      rec_start = 1'b0;
      cyc = 0;
      stopped = 0;
      while (done_cnt == 0 && cyc < 3000) begin
         stop_now = !stopped && (n_acc == stop_at || n_acc == n);
         rec_stop = stop_now;
         rec_audio_valid = !stopped && (n_acc < n);
         if (rec_audio_valid) rec_audio_data = samp[n_acc];
         @(negedge i_clk);
         hs = rec_audio_valid && rec_audio_ready;
         @(posedge i_clk); #1;
         if (hs) n_acc++;
         if (stop_now) stopped = 1;
         cyc++;
      end
      rec_stop = 1'b0;
      rec_audio_valid = 1'b0;
      if (done_cnt == 0) begin
         total++;
         bad++;
         $display("FAIL clip_timeout: rec_done not seen after %0d cycles, required within 3000", cyc);
         i_rst = 1'b1;
         @(posedge i_clk); #1;
         i_rst = 1'b0;
      end
      repeat (3) @(posedge i_clk);
      #1;
   endtask

   task automatic check_clip(input string name, input logic [AW-1:0] base,
                             input int mx, input int stop_at);
      int            k;
      int            j;
      logic [AW-1:0] e_addr[$];
      logic [DW-1:0] e_data[$];
      k = exp_accepts(samp.size(), stop_at, mx);
      total++;
      if (n_acc !== k) begin
         bad++;
         $display("FAIL %s accepts: got %0d required %0d", name, n_acc, k);
      end
      j = 0;
      for (int i = 0; i < k; i++) begin
`ifdef RECORD_CORE_DECIMATE_EN
         if (i % 2 != 0) continue;
`endif
         e_addr.push_back(AW'(base + AW'(1) + AW'(j)));
         e_data.push_back(samp[i]);
         j++;
      end
      e_addr.push_back(base);
      e_data.push_back(DW'(j));
      total++;
      if (wq_addr.size() !== e_addr.size()) begin
         bad++;
         $display("FAIL %s write_count: got %0d required %0d", name, wq_addr.size(), e_addr.size());
      end
      for (int i = 0; i < e_addr.size() && i < wq_addr.size(); i++) begin
         total++;
         if (wq_addr[i] !== e_addr[i] || wq_data[i] !== e_data[i]) begin
            bad++;
            $display("FAIL %s write%0d: got [%h]=%h required [%h]=%h",
                     name, i, wq_addr[i], wq_data[i], e_addr[i], e_data[i]);
         end
      end
      total++;
      if (rec_length !== AW'(j)) begin
         bad++;
         $display("FAIL %s rec_length: got %0d required %0d", name, rec_length, j);
      end
      total++;
      if (done_cnt !== 1) begin
         bad++;
         $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt);
      end
      total++;
      if (rec_busy !== 1'b0) begin
         bad++;
         $display("FAIL %s busy_after_done: got %b required 0", name, rec_busy);
      end
      total++;
      if (stab_bad !== 0) begin
         bad++;
         $display("FAIL %s stall_stability: got %0d changes required 0", name, stab_bad);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      total++;
      if (rec_busy !== 1'b0 || rec_done !== 1'b0 || rec_length !== '0 ||
          rec_audio_ready !== 1'b0 || rec_write !== 1'b0 || rec_addr !== '0 ||
          rec_writedata !== '0) begin
         bad++;
         $display("FAIL %s outputs: got busy=%b done=%b len=%h rdy=%b wr=%b addr=%h data=%h required all 0",
                  name, rec_busy, rec_done, rec_length, rec_audio_ready, rec_write, rec_addr, rec_writedata);
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      check_outputs_zero("reset_held");
      i_rst = 1'b0;
      @(posedge i_clk); #1;
      check_outputs_zero("reset_released");
   endtask

   task automatic test_basic();
      samp.delete();
      samp.push_back(32'hA);
      samp.push_back(32'hB);
      samp.push_back(32'hC);
      run_clip(23'h100, 23'd3, -1, 0);
      check_clip("basic", 23'h100, 3, -1);
   endtask

   task automatic test_stall();
      samp.delete();
      for (int i = 0; i < 12; i++) samp.push_back($urandom);
      run_clip(23'h2000, 23'd12, -1, 5);
      check_clip("stall", 23'h2000, 12, -1);
`ifndef RECORD_CORE_DECIMATE_EN
      total++;
      if (full_seen == 0 || full_viol !== 0) begin
         bad++;
         $display("FAIL stall_full_ready: got full_cycles=%0d ready_while_full=%0d required >0 and 0",
                  full_seen, full_viol);
      end
`endif
   endtask

   task automatic test_early_stop();
      samp.delete();
      for (int i = 0; i < 10; i++) samp.push_back($urandom);
      run_clip(23'h3000, 23'd100, 4, 0);
      check_clip("early_stop", 23'h3000, 100, 4);
   endtask

   task automatic test_max_zero();
      samp.delete();
      for (int i = 0; i < 3; i++) samp.push_back($urandom);
      run_clip(23'h4000, 23'd0, -1, 1);
      check_clip("max_zero", 23'h4000, 0, -1);
      total++;
      if (ready_hi !== 0) begin
         bad++;
         $display("FAIL max_zero_ready: got %0d ready cycles required 0", ready_hi);
      end
   endtask

   task automatic test_reset_drain();
      int cyc;
      bit hs;
      samp.delete();
      samp.push_back($urandom);
      samp.push_back($urandom);
      prep_clip(1000);
      start_clip(23'h40, 23'd2);
      cyc = 0;
      while (n_acc < 2 && cyc < 50) begin
         rec_audio_valid = 1'b1;
         rec_audio_data = samp[n_acc];
         @(negedge i_clk);
         hs = rec_audio_valid && rec_audio_ready;
         @(posedge i_clk); #1;
         if (hs) n_acc++;
         cyc++;
      end
      rec_audio_valid = 1'b0;
      @(posedge i_clk); #1;
      total++;
      if (n_acc !== 2 || rec_write !== 1'b1 || rec_busy !== 1'b1) begin
         bad++;
         $display("FAIL rst_drain_setup: got acc=%0d write=%b busy=%b required 2 1 1",
                  n_acc, rec_write, rec_busy);
      end
      i_rst = 1'b1;
      #1;
      check_outputs_zero("rst_drain");
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      repeat (4) @(posedge i_clk);
      #1;
      total++;
      if (wq_addr.size() !== 0 || done_cnt !== 0) begin
         bad++;
         $display("FAIL rst_drain_no_header: got writes=%0d done=%0d required 0 0",
                  wq_addr.size(), done_cnt);
      end
      samp.delete();
      samp.push_back($urandom);
      samp.push_back($urandom);
      run_clip(23'h40, 23'd2, -1, 0);
      check_clip("after_reset", 23'h40, 2, -1);
   endtask

   task automatic test_decimate();
      samp.delete();
      for (int i = 0; i < 6; i++) samp.push_back(32'hD0 + i);
      run_clip(23'h5000, 23'd10, 6, 0);
      check_clip("decimate", 23'h5000, 10, 6);
   endtask

   task automatic test_random();
      logic [AW-1:0] base;
      int            mx;
      int            n;
      int            st;
      for (int c = 0; c < 8; c++) begin
         base = (c == 0) ? 23'h7FFFFD : AW'($urandom);
         mx = $urandom_range(10, 0);
         n = $urandom_range(12, 0);
         st = ($urandom_range(1, 0) == 1) ? $urandom_range(n, 0) : -1;
         samp.delete();
         for (int i = 0; i < n; i++) samp.push_back($urandom);
         run_clip(base, AW'(mx), st, $urandom_range(3, 0));
         check_clip("random", base, mx, st);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_early_stop();
      test_max_zero();
      test_reset_drain();
      test_decimate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
